// File: rtl/clock_set_controller.sv
// -----------------------------------------------------------------------------
// clock_set_controller
//
// Front-panel controller for the HH:MM:SS timekeeper. Two raw push-buttons
// (mode, inc) are synchronized and debounced. A RUN / SET_HR / SET_MIN state
// machine then drives:
//   - the timekeeper count enable,
//   - one-cycle hour/minute increment strobes, with hold-to-auto-repeat,
//   - an inactivity timeout back to RUN,
//   - blanking flags so the display can blink the field being edited.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   btn_mode   in   raw mode button (asynchronous, active-high)
//   btn_inc    in   raw increment button (asynchronous, active-high)
//   en         out  count enable to timekeeper; registered, high only in RUN
//   hrup       out  one-cycle hour-increment strobe; registered
//   minup      out  one-cycle minute-increment strobe; registered
//   blank_hr   out  high = blank hour digits (blink off-phase, SET_HR only)
//   blank_min  out  high = blank minute digits (blink off-phase, SET_MIN only)
//   mode       out  current FSM state: 0 RUN, 1 SET_HR, 2 SET_MIN
//
// Latency from a clean raw level change to the resulting strobe or state
// change is DEBOUNCE_CYC+3 clock edges: 2 synchronizer edges, DEBOUNCE_CYC
// stable samples, and 1 edge for the registered FSM outputs.
// -----------------------------------------------------------------------------
module clock_set_controller #(
  parameter int unsigned DEBOUNCE_CYC     = 1_000_000,
  parameter int unsigned REPEAT_DELAY_CYC = 50_000_000,
  parameter int unsigned REPEAT_RATE_CYC  = 20_000_000,
  parameter int unsigned TIMEOUT_CYC      = 1_000_000_000,
  parameter int unsigned BLINK_CYC        = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       en,
  output logic       hrup,
  output logic       minup,
  output logic       blank_hr,
  output logic       blank_min,
  output logic [1:0] mode
);

  // ---------------------------------------------------------------------------
  // Counter widths and terminal values
  // ---------------------------------------------------------------------------
  localparam int unsigned RPT_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                                    REPEAT_DELAY_CYC : REPEAT_RATE_CYC;

  localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned RW = $clog2(RPT_MAX + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned BW = $clog2(BLINK_CYC + 1);

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_CYC - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

  // Bit positions of the two buttons in the conditioning vectors.
  localparam int unsigned BTN_INC  = 0;
  localparam int unsigned BTN_MODE = 1;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning: 2-flop synchronizer + debouncer + rising-edge detect
  // ---------------------------------------------------------------------------
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    level;     // debounced levels
  logic [1:0]    level_q;   // debounced levels, one cycle late
  logic [1:0]    press;     // one-cycle press events
  logic [DW-1:0] deb_cnt [2];

  assign raw = {btn_mode, btn_inc};

  // The count tracks consecutive synchronized samples that disagree with the
  // debounced level. A sample that agrees restarts it, so the level only moves
  // after DEBOUNCE_CYC consecutive equal samples of the new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_q <= '0;
      for (int b = 0; b < 2; b++) begin
        deb_cnt[b] <= '0;
      end
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      for (int b = 0; b < 2; b++) begin
        if (sync2[b] == level[b]) begin
          deb_cnt[b] <= '0;
        end else if (deb_cnt[b] == DEB_LAST) begin
          level[b]   <= sync2[b];
          deb_cnt[b] <= '0;
        end else begin
          deb_cnt[b] <= deb_cnt[b] + DW'(1);
        end
      end
    end
  end

  assign press = level & ~level_q;

  logic mode_press;
  logic inc_press;
  logic inc_level;

  assign mode_press = press[BTN_MODE];
  assign inc_press  = press[BTN_INC];
  assign inc_level  = level[BTN_INC];

  // ---------------------------------------------------------------------------
  // FSM state and its companion counters
  // ---------------------------------------------------------------------------
  state_t        state,       state_n;
  logic          rpt_active,  rpt_active_n;  // inc held after a press
  logic          rpt_fast,    rpt_fast_n;    // initial delay elapsed
  logic [RW-1:0] rpt_cnt,     rpt_cnt_n;
  logic [TW-1:0] tmo_cnt,     tmo_cnt_n;
  logic [BW-1:0] blink_cnt,   blink_cnt_n;
  logic          blink_phase, blink_phase_n; // 1 = off (blanked) phase
  logic          strobe;                     // increment the field being edited
  logic [RW-1:0] rpt_last;

  assign rpt_last = rpt_fast ? RATE_LAST : DELAY_LAST;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      rpt_active  <= 1'b0;
      rpt_fast    <= 1'b0;
      rpt_cnt     <= '0;
      tmo_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      en          <= 1'b0;
      hrup        <= 1'b0;
      minup       <= 1'b0;
    end else begin
      state       <= state_n;
      rpt_active  <= rpt_active_n;
      rpt_fast    <= rpt_fast_n;
      rpt_cnt     <= rpt_cnt_n;
      tmo_cnt     <= tmo_cnt_n;
      blink_cnt   <= blink_cnt_n;
      blink_phase <= blink_phase_n;
      // Registered from the next state so en moves on the same edge as mode.
      en          <= (state_n == RUN);
      hrup        <= strobe && (state == SET_HR);
      minup       <= strobe && (state == SET_MIN);
    end
  end

  // Priority inside a SET state: mode press, inc press, repeat strobe,
  // timeout, then plain counting. A mode press therefore beats a
  // simultaneous inc press, and any activity beats a coincident timeout.
  always_comb begin
    state_n       = state;
    strobe        = 1'b0;
    rpt_active_n  = rpt_active;
    rpt_fast_n    = rpt_fast;
    rpt_cnt_n     = rpt_cnt;
    tmo_cnt_n     = tmo_cnt;
    blink_cnt_n   = blink_cnt;
    blink_phase_n = blink_phase;

    case (state)
      RUN: begin
        if (mode_press) begin
          state_n = SET_HR;
        end
      end

      SET_HR, SET_MIN: begin
        if (mode_press) begin
          state_n = (state == SET_HR) ? SET_MIN : RUN;
        end else if (inc_press) begin
          strobe       = 1'b1;
          rpt_active_n = 1'b1;
          rpt_fast_n   = 1'b0;
          rpt_cnt_n    = '0;
        end else if (rpt_active && inc_level && (rpt_cnt == rpt_last)) begin
          strobe     = 1'b1;
          rpt_fast_n = 1'b1;
          rpt_cnt_n  = '0;
        end else if (tmo_cnt == TMO_LAST) begin
          state_n = RUN;
        end else begin
          tmo_cnt_n = tmo_cnt + TW'(1);
          if (rpt_active && inc_level) begin
            rpt_cnt_n = rpt_cnt + RW'(1);
          end else begin
            // Debounced release cancels the repeat.
            rpt_active_n = 1'b0;
            rpt_fast_n   = 1'b0;
            rpt_cnt_n    = '0;
          end
        end
      end

      default: begin
        state_n = RUN;
      end
    endcase

    // Every state change cancels the repeat and restarts the inactivity
    // timer. The timer is held at zero while in RUN.
    if ((state_n != state) || (state == RUN)) begin
      rpt_active_n = 1'b0;
      rpt_fast_n   = 1'b0;
      rpt_cnt_n    = '0;
      tmo_cnt_n    = '0;
    end else if (strobe) begin
      tmo_cnt_n = '0;
    end

    // Restarting the blink on entry and on each strobe keeps a freshly
    // edited field visible for a full half-period.
    if ((state_n != state) || strobe || (state == RUN)) begin
      blink_cnt_n   = '0;
      blink_phase_n = 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt_n   = '0;
      blink_phase_n = ~blink_phase;
    end else begin
      blink_cnt_n = blink_cnt + BW'(1);
    end
  end

  assign mode      = state;
  assign blank_hr  = blink_phase && (state == SET_HR);
  assign blank_min = blink_phase && (state == SET_MIN);

endmodule

// File: tb/tb_clock_set_controller.sv
// -----------------------------------------------------------------------------
// tb_clock_set_controller
//
// Directed scenarios plus a randomized button phase. A behavioural reference
// model, stepped once per clock edge, predicts every output. It works from
// the timing rules: debounce as "last N samples equal", repeat and timeout as
// elapsed time since the last event, blink as elapsed time / half-period.
// The model is compared against the DUT 1 time unit after every rising edge.
// -----------------------------------------------------------------------------
module tb_clock_set_controller;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RR  = 8;
  localparam int TO  = 100;
  localparam int BL  = 10;

  localparam int unsigned DMASK = (1 << DEB) - 1;
  localparam int unsigned HMASK = (1 << (DEB + 1)) - 1;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic       en;
  logic       hrup;
  logic       minup;
  logic       blank_hr;
  logic       blank_min;
  logic [1:0] mode;

  always #5 clk = ~clk;

  clock_set_controller #(
    .DEBOUNCE_CYC     (DEB),
    .REPEAT_DELAY_CYC (RD),
    .REPEAT_RATE_CYC  (RR),
    .TIMEOUT_CYC      (TO),
    .BLINK_CYC        (BL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .en        (en),
    .hrup      (hrup),
    .minup     (minup),
    .blank_hr  (blank_hr),
    .blank_min (blank_min),
    .mode      (mode)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int          cyc = 0;
  int          st;                  // 0 RUN, 1 SET_HR, 2 SET_MIN
  bit          en_m, hr_m, min_m, bh_m, bm_m;
  int unsigned h_mo, h_in;          // raw sample history, bit0 = newest
  bit          deb_mo, deb_in;      // debounced levels
  bit          pend_mo, pend_in;    // press seen, acted on next edge
  bit          rpt_on;
  int          press_t, act_t, blink_t;

  // Monitors of actual DUT strobes
  int hr_seen  = 0;
  int min_seen = 0;
  int min_times[$];

  // New debounced level: flips once the DEB samples that the debouncer has
  // seen (two synchronizer stages behind the raw pin) all agree.
  function automatic bit settle(input int unsigned h, input bit cur);
    int unsigned w;
    w = (h >> 1) & DMASK;
    if (w == 0) return 1'b0;
    if (w == DMASK) return 1'b1;
    return cur;
  endfunction

  task automatic model_reset();
    st = 0; en_m = 0; hr_m = 0; min_m = 0; bh_m = 0; bm_m = 0;
    h_mo = 0; h_in = 0; deb_mo = 0; deb_in = 0; pend_mo = 0; pend_in = 0;
    rpt_on = 0; press_t = 0; act_t = 0; blink_t = 0;
  endtask

  task automatic enter(input int s);
    st = s; rpt_on = 0; act_t = cyc; blink_t = cyc;
  endtask

  task automatic model_step();
    bit pm, pi, strobe, nl;
    int e;
    cyc++;
    pm = pend_mo; pi = pend_in; strobe = 0;
    hr_m = 0; min_m = 0;
    if (st == 0) begin
      if (pm) enter(1);
    end else if (pm) begin
      enter(st == 1 ? 2 : 0);
    end else if (pi) begin
      strobe = 1; rpt_on = 1; press_t = cyc;
    end else begin
      if (rpt_on && deb_in) begin
        e = cyc - press_t;
        if (e == RD || (e > RD && (e - RD) % RR == 0)) strobe = 1;
      end else begin
        rpt_on = 0;
      end
      if (!strobe && (cyc - act_t == TO)) enter(0);
    end
    if (strobe) begin
      hr_m = (st == 1); min_m = (st == 2); act_t = cyc; blink_t = cyc;
    end
    en_m = (st == 0);
    bh_m = (st == 1) && (((cyc - blink_t) / BL) % 2 == 1);
    bm_m = (st == 2) && (((cyc - blink_t) / BL) % 2 == 1);
    nl = settle(h_mo, deb_mo); pend_mo = nl & ~deb_mo; deb_mo = nl;
    nl = settle(h_in, deb_in); pend_in = nl & ~deb_in; deb_in = nl;
    h_mo = ((h_mo << 1) | int'(btn_mode)) & HMASK;
    h_in = ((h_in << 1) | int'(btn_inc)) & HMASK;
  endtask

  always @(posedge clk) begin
    if (rst) model_reset();
    else model_step();
    #1;
    check("en", en, en_m);
    check("hrup", hrup, hr_m);
    check("minup", minup, min_m);
    check("blank_hr", blank_hr, bh_m);
    check("blank_min", blank_min, bm_m);
    check("mode", mode, st);
    check("strobe_excl", (hrup && minup) || ((hrup || minup) && en), 0);
    if (hrup) hr_seen++;
    if (minup) begin
      min_seen++;
      min_times.push_back(cyc);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic press_mode();
    @(negedge clk); btn_mode = 1'b1;
    repeat (10) @(negedge clk);
    btn_mode = 1'b0;
    repeat (15) @(negedge clk);
  endtask

  task automatic hold_inc(input int n, input int gap);
    @(negedge clk); btn_inc = 1'b1;
    repeat (n) @(negedge clk);
    btn_inc = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_mode(input logic [1:0] target, input int limit, output int edges);
    edges = -1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #2;
      if (mode == target) begin
        edges = k;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int k, h0, m0, m1, nmin, got;

    rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_en", en, 0);
    check("rst_mode", mode, 0);
    rst = 1'b0;
    @(posedge clk); #2;
    check("en_first_edge", en, 1);
    check("mode_after_rst", mode, 0);

    // 1: mode sequencing and fixed latency
    @(negedge clk); btn_mode = 1'b1;
    wait_mode(2'd1, 30, k);
    check("mode_latency", k, DEB + 3);
    check("en_in_set_hr", en, 0);
    repeat (4) @(negedge clk);
    btn_mode = 1'b0;
    repeat (15) @(negedge clk);
    press_mode();
    check("mode_set_min", mode, 2);
    press_mode();
    check("mode_back_run", mode, 0);
    check("en_back_run", en, 1);

    // 2: glitchy inc in SET_HR, then a clean press
    press_mode();
    check("mode_glitch_set_hr", mode, 1);
    h0 = hr_seen; m0 = min_seen;
    @(negedge clk); btn_inc = 1'b1;
    repeat (3) @(negedge clk); btn_inc = 1'b0;
    repeat (1) @(negedge clk); btn_inc = 1'b1;
    repeat (3) @(negedge clk); btn_inc = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_no_hrup", hr_seen - h0, 0);
    hold_inc(10, 15);
    check("clean_one_hrup", hr_seen - h0, 1);
    check("clean_no_minup", min_seen - m0, 0);

    // 3: auto-repeat in SET_MIN, then the same hold in RUN
    press_mode();
    check("mode_rpt_set_min", mode, 2);
    m0 = min_seen;
    min_times.delete();
    hold_inc(60, 20);
    nmin = min_seen - m0;
    check("repeat_count", nmin, 6);
    if (nmin >= 3) begin
      check("repeat_delay", min_times[1] - min_times[0], RD);
      check("repeat_rate", min_times[2] - min_times[1], RR);
    end
    press_mode();
    check("mode_run_hold", mode, 0);
    h0 = hr_seen; m0 = min_seen;
    hold_inc(60, 20);
    check("run_no_strobe", (hr_seen - h0) + (min_seen - m0), 0);

    // 4: simultaneous mode + inc in SET_HR
    press_mode();
    h0 = hr_seen; m0 = min_seen;
    @(negedge clk); btn_mode = 1'b1; btn_inc = 1'b1;
    repeat (10) @(negedge clk);
    btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (15) @(negedge clk);
    check("simul_mode", mode, 2);
    check("simul_no_strobe", (hr_seen - h0) + (min_seen - m0), 0);

    // 5: blink and inactivity timeout in SET_HR
    press_mode();
    check("mode_pre_timeout", mode, 0);
    @(negedge clk); btn_mode = 1'b1;
    wait_mode(2'd1, 30, k);
    check("entry_latency", k, DEB + 3);
    btn_mode = 1'b0;
    got = -1;
    for (int j = 1; j <= 120; j++) begin
      @(posedge clk); #2;
      if (j == 9)  check("blink_vis_9", blank_hr, 0);
      if (j == 10) check("blink_off_10", blank_hr, 1);
      if (j == 19) check("blink_off_19", blank_hr, 1);
      if (j == 20) check("blink_vis_20", blank_hr, 0);
      if (mode == 2'd0) begin
        got = j;
        break;
      end
    end
    check("timeout_cycles", got, TO);
    check("timeout_en", en, 1);
    check("timeout_blank", blank_hr, 0);

    // 6: reset mid-repeat with inc held in SET_MIN
    press_mode();
    press_mode();
    check("mode_pre_reset", mode, 2);
    m0 = min_seen;
    @(negedge clk); btn_inc = 1'b1;
    repeat (32) @(negedge clk);
    check("pre_reset_minups", min_seen - m0, 2);
    rst = 1'b1;
    #1;
    check("rst_now_en", en, 0);
    check("rst_now_hrup", hrup, 0);
    check("rst_now_minup", minup, 0);
    check("rst_now_blank", blank_hr | blank_min, 0);
    check("rst_now_mode", mode, 0);
    m1 = min_seen;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    btn_inc = 1'b0;
    repeat (20) @(negedge clk);
    check("post_reset_mode", mode, 0);
    check("post_reset_en", en, 1);
    check("post_reset_no_minup", min_seen - m1, 0);

    // Randomized buttons, checked cycle by cycle against the model
    for (int s = 0; s < 140; s++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
      btn_mode = ($urandom_range(0, 7) == 0);
      btn_inc  = ($urandom_range(0, 2) == 0);
      repeat ($urandom_range(1, 30)) @(negedge clk);
    end
    btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (30) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
Front-panel controller that sequences the HH:MM:SS timekeeping counter. It debounces two raw push-buttons (mode, inc) and runs a RUN / SET_HR / SET_MIN state machine. It drives the counter's count-enable and its one-cycle hour/minute increment strobes, with hold-to-auto-repeat and inactivity timeout. It also emits blanking flags so the display can blink the field being edited.

Parameters:
DEBOUNCE_CYC, 1_000_000, consecutive stable cycles required before a debounced level changes (10 ms at 100 MHz)
REPEAT_DELAY_CYC, 50_000_000, hold time after a press before auto-repeat starts
REPEAT_RATE_CYC, 20_000_000, interval between auto-repeat strobes
TIMEOUT_CYC, 1_000_000_000, inactivity time in a SET state before forced return to RUN
BLINK_CYC, 25_000_000, half-period of the edit-field blink

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  asynchronous, active-high reset
btn_mode  input  1  raw mode button, asynchronous, active-high
btn_inc  input  1  raw increment button, asynchronous, active-high
en  output  1  count enable to timekeeper; registered
hrup  output  1  one-cycle hour-increment strobe; registered
minup  output  1  one-cycle minute-increment strobe; registered
blank_hr  output  1  high = blank hour digits (blink off-phase)
blank_min  output  1  high = blank minute digits (blink off-phase)
mode  output  2  current state: 0 RUN, 1 SET_HR, 2 SET_MIN; 3 never driven

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0, including en; state RUN.
  - All counters cleared; synchronizer and debounce flops 0.
  - en rises on the first clk edge after rst deasserts.
- Input conditioning, per button:
  - 2-flop synchronizer.
  - Debouncer: the debounced level takes the synchronized value only after DEBOUNCE_CYC consecutive equal samples. Any mismatch restarts the count.
  - A rising edge of the debounced level produces a one-cycle internal press event.
- Latency: a clean raw level change yields the output strobe / state change exactly DEBOUNCE_CYC+3 clk edges after the first edge that samples the new level. This is fixed and the bench checks it.
- FSM:
  - A mode press advances RUN -> SET_HR -> SET_MIN -> RUN.
  - en = 1 only in RUN; it is registered, so it changes on the same edge as mode.
- Inc press:
  - In SET_HR: hrup = 1 for exactly one cycle.
  - In SET_MIN: minup = 1 for exactly one cycle.
  - In RUN: ignored, no strobe.
  - hrup and minup are never both high, and never high while en = 1.
  - Wrap-around (23->0, 59->0) is the timekeeper's job; this block only strobes.
- Auto-repeat:
  - Starts if the debounced inc stays high for REPEAT_DELAY_CYC cycles after the initial strobe.
  - Then one further strobe every REPEAT_RATE_CYC cycles while held.
  - Debounced release, any mode press, or any state change cancels repeat and clears its counters.
- Simultaneous mode and inc press in the same cycle: mode wins; state advances, no strobe, repeat cancelled.
- Timeout:
  - In SET_HR/SET_MIN, an inactivity counter clears on every press event and on every repeat strobe.
  - On reaching TIMEOUT_CYC: state goes to RUN, en = 1, no strobe.
  - The counter is held at 0 in RUN.
- Blink:
  - The phase counter clears on every state entry and on every hrup/minup strobe, so a freshly edited field is always visible.
  - The phase toggles every BLINK_CYC cycles, starting in the visible phase.
  - blank_hr = off-phase AND SET_HR; blank_min = off-phase AND SET_MIN.
  - Both are 0 in RUN.
- Widths: each counter is $clog2(param+1) bits and saturates or clears exactly at its terminal value, never wraps silently.
- Reset mid-operation (held button, mid-repeat, mid-debounce):
  - Immediate return to reset values; no strobe on release.
  - A button still held across reset release must first debounce high; this then counts as a new press.

Test Plan:
Bench overrides: DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=20, REPEAT_RATE_CYC=8, TIMEOUT_CYC=100, BLINK_CYC=10.
1. Reset release -> en 0 during rst, 1 on first edge after; mode=0. Clean btn_mode pulse of 10 cycles -> mode=1 and en=0 exactly 7 edges after first sampled high. Second press -> mode=2. Third press -> mode=0, en=1.
2. Glitch: btn_inc high 3 cycles, low 1, high 3, in SET_HR -> no hrup. Then stable high 10 cycles -> exactly one hrup one-cycle pulse, minup stays 0.
3. Hold btn_inc 60 cycles in SET_MIN -> strobes at press, +20, +28, +36, +44, +52 (6 minup pulses). Release -> no further strobes. Same hold in RUN -> zero strobes.
4. btn_mode and btn_inc rise on the same cycle in SET_HR -> mode=2, no hrup/minup.
5. Enter SET_HR, no activity -> blank_hr pattern 10 visible / 10 blank cycles. At cycle 100 after entry: mode=0, en=1, blank_hr=0.
6. Assert rst mid-repeat with btn_inc held in SET_MIN -> all outputs 0 immediately. After release: mode=0, en=1, no minup ever emitted.
